// File: rtl/collector_pkg.sv
// Shared definitions for the packet collector: FSM state type and packet field offsets.
package collector_pkg;

    typedef enum logic {
        WaitReq,
        ReceiveData
    } collectorState_e;

    function automatic int senderIdLsb();
        return 0;
    endfunction

    function automatic int packetIdLsb(input int srcWidth);
        return srcWidth;
    endfunction

    function automatic int packetIdMsb(input int idWidth, input int srcWidth);
        return idWidth + srcWidth - 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output; DEPTH must be a power of two.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int PtrWidth  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wrEn,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic                  rdEn,
    output logic [DATA_WIDTH-1:0] rdData,
    output logic                  empty,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PtrWidth-1:0]   wrPtr;
    logic [PtrWidth-1:0]   rdPtr;
    logic [PtrWidth:0]     count;
    logic                  doWrite;
    logic                  doRead;

    assign empty   = (count == '0);
    assign full    = (count == (PtrWidth + 1)'(DEPTH));
    assign doWrite = wrEn && !full;
    assign doRead  = rdEn && !empty;
    assign rdData  = mem[rdPtr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doWrite) wrPtr <= wrPtr + PtrWidth'(1);
            if (doRead)  rdPtr <= rdPtr + PtrWidth'(1);
            case ({doWrite, doRead})
                2'b10:   count <= count + (PtrWidth + 1)'(1);
                2'b01:   count <= count - (PtrWidth + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (doWrite) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/packet_collector_fifo.sv
// Collects packets from a router local port into a FIFO for the PE, tracking
// receive statistics and PacketID sequence errors.
module packet_collector_fifo
    import collector_pkg::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ID_WIDTH   = 10,
    parameter int                  SRC_WIDTH  = 6,
    parameter int                  DEPTH      = 4,
    parameter logic [SRC_WIDTH-1:0] MODULE_ID = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] PacketIn,
    input  logic                  ReqUpStr,
    output logic                  GntUpStr,
    output logic                  UpStrFull,
    input  logic                  RdEn,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  Empty,
    output logic [15:0]           RxCount,
    output logic [7:0]            SeqErrCount,
    output logic [31:0]           CycleCounter,
    output logic [31:0]           LastRxTime
);

    localparam int IdMsb = packetIdMsb(ID_WIDTH, SRC_WIDTH);
    localparam int IdLsb = packetIdLsb(SRC_WIDTH);

    collectorState_e     state;
    collectorState_e     stateNext;
    logic                accept;
    logic                fifoFull;
    logic [ID_WIDTH-1:0] packetId;
    logic [ID_WIDTH-1:0] lastId;
    logic                firstPkt;
    logic                seqBreak;

    assign packetId  = PacketIn[IdMsb:IdLsb];
    assign GntUpStr  = (state == ReceiveData);
    assign UpStrFull = fifoFull;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= WaitReq;
        else        state <= stateNext;
    end

    // Full is judged on the registered count only, so a same-cycle pop cannot enable a grant.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        unique case (state)
            WaitReq: begin
                if (ReqUpStr && !fifoFull) begin
                    accept    = 1'b1;
                    stateNext = ReceiveData;
                end
            end
            ReceiveData: stateNext = WaitReq;
            default:     stateNext = WaitReq;
        endcase
    end

    sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) uFifo (
        .clk   (clk),
        .reset (reset),
        .wrEn  (accept),
        .wrData(PacketIn),
        .rdEn  (RdEn),
        .rdData(DataOut),
        .empty (Empty),
        .full  (fifoFull)
    );

    assign seqBreak = !firstPkt && (packetId != lastId + ID_WIDTH'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RxCount      <= '0;
            SeqErrCount  <= '0;
            CycleCounter <= '0;
            LastRxTime   <= '0;
            lastId       <= '0;
            firstPkt     <= 1'b1;
        end else begin
            CycleCounter <= CycleCounter + 32'd1;
            if (accept) begin
                RxCount    <= RxCount + 16'd1;
                LastRxTime <= CycleCounter;
                lastId     <= packetId;
                firstPkt   <= 1'b0;
                if (seqBreak && SeqErrCount != 8'hFF) SeqErrCount <= SeqErrCount + 8'd1;
            end
        end
    end

`ifdef COLLECTOR_SIM_LOG
    always @(posedge clk) begin
        if (reset && accept) begin
            $display("Collector_Log_%0d: %0t; %0d; %0d; %0d; %0d", MODULE_ID, $time, CycleCounter,
                     PacketIn[senderIdLsb() +: SRC_WIDTH], MODULE_ID, packetId);
        end
    end
`endif

endmodule

// File: tb/tb_packet_collector_fifo.sv
// Randomized and directed checks of packet_collector_fifo against a queue-based reference model.
module tb_packet_collector_fifo;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [31:0] pktIn;
    logic        req;
    logic        rdEn;
    logic        GntUpStr;
    logic        UpStrFull;
    logic [31:0] DataOut;
    logic        Empty;
    logic [15:0] RxCount;
    logic [7:0]  SeqErrCount;
    logic [31:0] CycleCounter;
    logic [31:0] LastRxTime;

    int checks = 0;
    int errors = 0;

    packet_collector_fifo #(
        .DATA_WIDTH(32),
        .ID_WIDTH  (10),
        .SRC_WIDTH (6),
        .DEPTH     (DEPTH),
        .MODULE_ID (6'd3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PacketIn    (pktIn),
        .ReqUpStr    (req),
        .GntUpStr    (GntUpStr),
        .UpStrFull   (UpStrFull),
        .RdEn        (rdEn),
        .DataOut     (DataOut),
        .Empty       (Empty),
        .RxCount     (RxCount),
        .SeqErrCount (SeqErrCount),
        .CycleCounter(CycleCounter),
        .LastRxTime  (LastRxTime)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction-level view of what the collector must hold.
    logic [31:0] mq[$];
    logic [31:0] mCyc;
    logic [31:0] mLast;
    logic [15:0] mRx;
    int          mSeq;
    logic [9:0]  mLastId;
    bit          mFirst;
    bit          mGnt;

    always @(posedge clk or negedge reset) begin
        bit         acc;
        bit         pop;
        logic [9:0] id;
        if (!reset) begin
            mq.delete();
            mCyc = 0; mLast = 0; mRx = 0; mSeq = 0; mLastId = 0; mFirst = 1; mGnt = 0;
        end else begin
            // At most one accept per two edges, never when the queue already holds DEPTH.
            acc = req && (mq.size() < DEPTH) && !mGnt;
            pop = rdEn && (mq.size() > 0);
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(pktIn);
                mRx   = mRx + 16'd1;
                mLast = mCyc;
                id    = pktIn[15:6];
                if (!mFirst && id != 10'((int'(mLastId) + 1) % 1024) && mSeq < 255) mSeq++;
                mLastId = id;
                mFirst  = 0;
            end
            mGnt = acc;
            mCyc = mCyc + 32'd1;
        end
    end

    always @(negedge clk) begin
        check("gnt", 32'(GntUpStr), 32'(mGnt));
        check("empty", 32'(Empty), 32'(mq.size() == 0));
        check("full", 32'(UpStrFull), 32'(mq.size() == DEPTH));
        if (mq.size() > 0) check("dataOut", DataOut, mq[0]);
        check("rxCount", 32'(RxCount), 32'(mRx));
        check("seqErr", 32'(SeqErrCount), 32'(mSeq));
        check("cycle", CycleCounter, mCyc);
        check("lastRx", LastRxTime, mLast);
    end

    function automatic logic [31:0] mkPkt(input logic [9:0] id, input logic [15:0] tag);
        return {tag, id, 6'd5};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic sendPkt(input logic [9:0] id, input logic [15:0] tag);
        pktIn = mkPkt(id, tag);
        req   = 1'b1;
        step();
        req   = 1'b0;
        step();
    endtask

    initial begin
        int          grants;
        logic [9:0]  fid;
        logic [9:0]  rid;
        logic [31:0] p2;
        logic [31:0] p3;

        reset = 1'b1; req = 1'b0; rdEn = 1'b0; pktIn = '0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check("rst_gnt", 32'(GntUpStr), 32'd0);
        check("rst_empty", 32'(Empty), 32'd1);
        check("rst_full", 32'(UpStrFull), 32'd0);
        check("rst_cycle", CycleCounter, 32'd0);

        // Single packet
        pktIn = 32'h0000_0A05;
        req   = 1'b1;
        step();
        req   = 1'b0;
        check("single_gnt_hi", 32'(GntUpStr), 32'd1);
        step();
        check("single_gnt_lo", 32'(GntUpStr), 32'd0);
        check("single_empty", 32'(Empty), 32'd0);
        check("single_data", DataOut, 32'h0000_0A05);
        check("single_rx", 32'(RxCount), 32'd1);
        check("single_seq", 32'(SeqErrCount), 32'd0);
        check("single_lastRx", LastRxTime, 32'd0);

        // Fill with Req held
        doReset();
        fid    = 10'd100;
        grants = 0;
        pktIn  = mkPkt(fid, 16'h1000);
        req    = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (GntUpStr) begin
                grants++;
                fid   = fid + 10'd1;
                pktIn = mkPkt(fid, 16'h1000 + 16'(grants));
            end
        end
        check("fill_grants", 32'(grants), 32'd4);
        check("fill_full", 32'(UpStrFull), 32'd1);
        rdEn = 1'b1;
        step();
        rdEn = 1'b0;
        check("fill_pop_nogrant", 32'(GntUpStr), 32'd0);
        step();
        check("fill_5th_grant", 32'(GntUpStr), 32'd1);
        req = 1'b0;
        step();
        check("fill_seq", 32'(SeqErrCount), 32'd0);

        // Sequence errors and ID wrap
        doReset();
        rdEn = 1'b1;
        sendPkt(10'd1, 16'h2001);
        sendPkt(10'd2, 16'h2002);
        sendPkt(10'd5, 16'h2003);
        sendPkt(10'd6, 16'h2004);
        check("seq_1256", 32'(SeqErrCount), 32'd1);
        doReset();
        sendPkt(10'd1023, 16'h2005);
        sendPkt(10'd0, 16'h2006);
        check("seq_wrap", 32'(SeqErrCount), 32'd0);
        check("seq_wrap_rx", 32'(RxCount), 32'd2);

        // Simultaneous pop and grant at count 2
        doReset();
        rdEn = 1'b0;
        sendPkt(10'd10, 16'h3001);
        sendPkt(10'd11, 16'h3002);
        p2    = mkPkt(10'd11, 16'h3002);
        p3    = mkPkt(10'd12, 16'h3003);
        pktIn = p3;
        req   = 1'b1;
        rdEn  = 1'b1;
        step();
        req   = 1'b0;
        rdEn  = 1'b0;
        check("sim_gnt", 32'(GntUpStr), 32'd1);
        check("sim_head", DataOut, p2);
        check("sim_notfull", 32'(UpStrFull), 32'd0);
        rdEn = 1'b1;
        step();
        check("sim_drain2", DataOut, p3);
        check("sim_notempty", 32'(Empty), 32'd0);
        step();
        check("sim_drained", 32'(Empty), 32'd1);

        // Underflow and saturation
        doReset();
        rdEn = 1'b1;
        repeat (3) step();
        check("uflow_empty", 32'(Empty), 32'd1);
        check("uflow_rx", 32'(RxCount), 32'd0);
        for (int i = 0; i < 300; i++) sendPkt(10'd5, 16'(i));
        check("sat_seq", 32'(SeqErrCount), 32'd255);
        check("sat_rx", 32'(RxCount), 32'd300);

        // Reset during RECEIVE_DATA with 3 entries
        doReset();
        rdEn = 1'b0;
        sendPkt(10'd40, 16'h4001);
        sendPkt(10'd41, 16'h4002);
        pktIn = mkPkt(10'd42, 16'h4003);
        req   = 1'b1;
        step();
        req   = 1'b0;
        check("mid_gnt_before", 32'(GntUpStr), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_gnt", 32'(GntUpStr), 32'd0);
        check("mid_empty", 32'(Empty), 32'd1);
        check("mid_rx", 32'(RxCount), 32'd0);
        check("mid_cycle", CycleCounter, 32'd0);
        check("mid_lastRx", LastRxTime, 32'd0);
        step();
        reset = 1'b1;
        sendPkt(10'd77, 16'h4004);
        check("mid_first_noerr", 32'(SeqErrCount), 32'd0);
        check("mid_first_rx", 32'(RxCount), 32'd1);

        // Randomized traffic, checked every cycle by the model
        doReset();
        rid = 10'($urandom());
        for (int i = 0; i < 2000; i++) begin
            req  = 1'($urandom_range(0, 1));
            rdEn = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 3) != 0) rid = rid + 10'd1;
            else                           rid = 10'($urandom());
            pktIn = mkPkt(rid, 16'($urandom()));
            step();
        end
        req  = 1'b0;
        rdEn = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_collector_fifo.md
PACKET_COLLECTOR_FIFO -- requirements
Module: packet_collector_fifo

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_WIDTH, 32, packet width in bits.
REQ-002 SHALL have parameters: ID_WIDTH, 10, PacketID field width; SRC_WIDTH, 6, SenderID field width; DEPTH, 4, FIFO entries (power of 2, >=2); MODULE_ID, 0, this collector's ID (SRC_WIDTH bits).
REQ-003 SHALL have ports (name, direction, width, meaning): clk, in, 1, single clock, rising edge.
REQ-004 reset, in, 1, asynchronous, active-low reset.
REQ-005 PacketIn, in, DATA_WIDTH, packet from the router local port.
REQ-006 ReqUpStr, in, 1, router request to deliver PacketIn.
REQ-007 GntUpStr, out, 1, one-cycle grant; the packet was captured.
REQ-008 UpStrFull, out, 1, high while the FIFO holds DEPTH entries.
REQ-009 RdEn, in, 1, PE pop request; DataOut, out, DATA_WIDTH, FIFO head (first-word-fall-through); Empty, out, 1, FIFO empty.
REQ-010 RxCount, out, 16, accepted packets (wraps); SeqErrCount, out, 8, PacketID sequence errors (saturates at 255); CycleCounter, out, 32, free-running cycle count; LastRxTime, out, 32, CycleCounter value at the last accept.

Function
REQ-011 Packet fields SHALL be: PacketID = PacketIn[ID_WIDTH+SRC_WIDTH-1 : SRC_WIDTH]; SenderID = PacketIn[SRC_WIDTH-1:0]; all DATA_WIDTH bits are stored.
REQ-012 The FSM SHALL have two states, WAIT_REQ and RECEIVE_DATA.
REQ-013 WAIT_REQ: if ReqUpStr=1 and count<DEPTH at the edge, then GntUpStr<=1, write PacketIn to the FIFO, update stats, next state RECEIVE_DATA; otherwise stay in WAIT_REQ with GntUpStr<=0.
REQ-014 RECEIVE_DATA: GntUpStr<=0 and next state WAIT_REQ unconditionally, so peak acceptance is one packet per 2 cycles.
REQ-015 Grant latency SHALL be 1 cycle from Req sampled with FIFO not full; Req held while full SHALL be granted on the first WAIT_REQ edge at which count<DEPTH.
REQ-016 The full decision SHALL use the registered count only; a pop in the same cycle does not enable a grant.
REQ-017 UpStrFull SHALL equal (count==DEPTH); Empty SHALL equal (count==0).
REQ-018 A pop SHALL occur when RdEn=1 and Empty=0; RdEn while empty SHALL be ignored with no state change.
REQ-019 A simultaneous write and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-020 On each accept, RxCount SHALL increment by 1 (16-bit wrap) and LastRxTime SHALL load the current CycleCounter.
REQ-021 On every accept except the first since reset, if PacketID != (last PacketID + 1) mod 2^ID_WIDTH, SeqErrCount SHALL increment, saturating at 255; the last PacketID then updates.
REQ-022 CycleCounter SHALL increment every clock and wrap at 2^32.
REQ-023 In simulation only, each accept SHALL append "time; CycleCounter; SenderID; MODULE_ID; PacketID" to file Collector_Log_<MODULE_ID>.txt.

Reset
REQ-024 While reset=0, all of the following SHALL hold asynchronously: state WAIT_REQ, GntUpStr=0, UpStrFull=0, Empty=1, FIFO pointers and count=0, RxCount=0, SeqErrCount=0, CycleCounter=0, LastRxTime=0, first-packet flag set. DataOut is don't-care.
REQ-025 Reset asserted in RECEIVE_DATA SHALL drop GntUpStr immediately and discard all buffered packets.

Structure
REQ-026 A shared package collector_pkg SHALL hold the state enum and the field-offset functions for PacketID and SenderID.
REQ-027 The FIFO SHALL be a sub-module sync_fifo (DATA_WIDTH, DEPTH) with FWFT output, instantiated once.

Verification
REQ-028 Single packet: PacketIn=0x0000_0A05 (ID=0x028, src=5), Req for 1 cycle -> GntUpStr high for exactly 1 cycle, 1 cycle later; Empty=0; DataOut=0x0000_0A05; RxCount=1; SeqErrCount=0.
REQ-029 Fill: DEPTH=4, Req held continuously, RdEn=0, sequential IDs -> 4 grants spaced 2 cycles apart; UpStrFull=1 after the 4th grant; no further grant; pop once -> 5th grant on the next WAIT_REQ edge.
REQ-030 Sequence error: IDs 1, 2, 5, 6 -> SeqErrCount=1; IDs 1023 then 0 -> no error (wrap).
REQ-031 Simultaneous pop and grant with count=2 -> count stays 2; FIFO order is preserved on drain.
REQ-032 Underflow/saturation: RdEn while Empty -> no change; 300 out-of-order accepts -> SeqErrCount=255.
REQ-033 Reset mid-transfer: reset low during RECEIVE_DATA with 3 entries -> GntUpStr=0, Empty=1, all counters 0 immediately; first packet after release is not counted as a sequence error.
